instr_fetch_unit: RTL and testbench

Front-end fetch stage: the consumer of the Branch Facility's next-instruction address and the producer of the 32-bit instruction word fed to Instruction Identify.
- Prefetches sequential words from instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers fetched words in a small queue.
- Flushes and refetches whenever the address chosen by the Branch Facility is not the next sequential one.

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit_queue.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    // One fetched word together with where it came from and whether memory flagged it.
    typedef struct packed {
        logic [0:63] addr;
        logic [0:31] instr;
        logic        err;
    } fetch_entry_t;

    // Word-align an address; in 32-bit mode the upper half is forced to zero as well.
    function automatic logic [0:63] mask_addr(input logic [0:63] addr, input logic mode32);
        logic [0:63] r;
        r = addr;
        r[62:63] = 2'b00;
        if (mode32) begin
            r[0:31] = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory port: valid/ready request channel and in-order response channel.
interface fetch_mem_if;

    logic        req_valid;
    logic        req_ready;
    logic [0:63] req_addr;
    logic        rsp_valid;
    logic [0:31] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Small synchronous FIFO holding fetched words; flush wins over a same-cycle push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // The request credit limit must make pushing into a full queue impossible.
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_push) begin
            assert (count < CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: prefetches sequential instruction words, queues them and
// refetches from the Branch Facility address whenever it is not sequential.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_32b_mode,
    input  logic [0:63] i_next_instr_addr,
    output logic [0:31] o_instr,
    output logic [0:63] o_instr_addr,
    output logic        o_instr_valid,
    output logic        o_instr_err,
    input  logic        i_instr_ready,
    output logic        o_stall,
    fetch_mem_if.master mem,
    output logic        o_err_misaligned
);

    logic [0:63]      fpc;
    logic [0:63]      rsp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   credit_used;
    logic             active;
    logic             req_fire;
    logic             rsp_keep;
    logic             consume;
    logic             is_seq;
    logic             redirect;
    logic             pop;
    logic             push;
    logic [0:63]      seq_addr;
    logic [0:63]      redirect_addr;
    fetch_entry_t     q_head;
    fetch_entry_t     push_entry;

    // Queued words plus outstanding requests never exceed DEPTH, so every
    // response is guaranteed a slot. active holds requests off during reset.
    assign credit_used   = {1'b0, q_count} + {1'b0, inflight};
    assign mem.req_valid = active & (credit_used < (CNT_W + 1)'(DEPTH));
    assign mem.req_addr  = fpc;
    assign req_fire      = mem.req_valid & mem.req_ready;

    assign o_instr_valid = (q_count != '0);
    assign o_stall       = ~o_instr_valid;
    assign o_instr       = o_instr_valid ? q_head.instr : '0;
    assign o_instr_addr  = o_instr_valid ? q_head.addr : '0;
    assign o_instr_err   = o_instr_valid & q_head.err;

    assign consume       = o_instr_valid & i_instr_ready;
    assign seq_addr      = mask_addr(q_head.addr + 64'(INSTR_BYTES), i_32b_mode);
    assign is_seq        = (i_next_instr_addr == seq_addr);
    assign redirect      = consume & ~is_seq;
    assign pop           = consume & is_seq;
    assign redirect_addr = mask_addr(i_next_instr_addr, i_32b_mode);

    // Responses to requests issued before a redirect are dropped while discard runs down.
    assign rsp_keep      = mem.rsp_valid & (discard == '0);
    assign push          = rsp_keep & ~redirect;
    assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(mem.rsp_valid);

    // Assemble the queue entry from the tracked response address and memory data.
    always_comb begin
        push_entry       = '0;
        push_entry.addr  = rsp_pc;
        push_entry.instr = mem.rsp_data;
        push_entry.err   = mem.rsp_err;
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (q_head),
        .count      (q_count)
    );

    // Fetch PC and response PC: step by one word, or jump together on redirect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fpc    <= '0;
            rsp_pc <= '0;
        end else if (redirect) begin
            fpc    <= redirect_addr;
            rsp_pc <= redirect_addr;
        end else begin
            if (req_fire) begin
                fpc <= mask_addr(fpc + 64'(INSTR_BYTES), i_32b_mode);
            end
            if (rsp_keep) begin
                rsp_pc <= mask_addr(rsp_pc + 64'(INSTR_BYTES), i_32b_mode);
            end
        end
    end

    // Outstanding-request count; on redirect everything still in flight becomes stale.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                discard <= inflight_next;
            end else if (mem.rsp_valid && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
        end
    end

    // Misaligned-target pulse and the post-reset request enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_misaligned <= 1'b0;
            active           <= 1'b0;
        end else begin
            o_err_misaligned <= redirect & (i_next_instr_addr[62:63] != 2'b00);
            active           <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with random
// latency/backpressure and a program-order reference for the presented stream.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [63:0] NO_ERR = 64'hDEAD_0000_0000_0001;
    localparam logic [63:0] SENT   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_32b_mode = 1'b0;
    logic [0:63] i_next_instr_addr = '0;
    logic [0:31] o_instr;
    logic [0:63] o_instr_addr;
    logic        o_instr_valid;
    logic        o_instr_err;
    logic        i_instr_ready = 1'b0;
    logic        o_stall;
    logic        o_err_misaligned;

    fetch_mem_if mem_bus ();

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_32b_mode        (i_32b_mode),
        .i_next_instr_addr (i_next_instr_addr),
        .o_instr           (o_instr),
        .o_instr_addr      (o_instr_addr),
        .o_instr_valid     (o_instr_valid),
        .o_instr_err       (o_instr_err),
        .i_instr_ready     (i_instr_ready),
        .o_stall           (o_stall),
        .mem               (mem_bus),
        .o_err_misaligned  (o_err_misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    int errors = 0;
    int checks = 0;

    pend_t       mem_q[$];
    int          lat_min, lat_max, mem_rdy_pct, cons_pct, redir_pct;
    logic [63:0] err_addr;
    logic [63:0] exp_pc, exp_req_pc;
    logic        exp_mis;
    int          cyc = 0;

    logic        arm_en;
    logic [63:0] arm_at, arm_to;
    logic        cap_on;
    int          cap_n;
    logic [63:0] post_acc [2];
    logic        pres_pend;
    logic [63:0] post_pres;
    int          dropped;
    int          mis_pulses, acc_count, first_acc_cyc, first_val_cyc, val_count;
    int          win_lo, win_hi;
    logic [63:0] last_acc;
    logic        seen_err8;
    logic [31:0] data_at8;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] msk(input logic [63:0] a, input logic m32);
        logic [63:0] r;
        r = a & ~64'h3;
        if (m32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1000_0000 + 32'(a >> 2);
    endfunction

    function automatic logic [63:0] rand_target(input logic m32);
        logic [63:0] t;
        t = 64'($urandom_range(511)) * 64'd4;
        if ($urandom_range(3) == 0) t = t + 64'($urandom_range(3, 1));
        if (m32 && $urandom_range(3) == 0) t = {$urandom, $urandom};
        return t;
    endfunction

    task automatic clear_stats();
        arm_en = 1'b0;
        cap_on = 1'b0;
        cap_n = 0;
        post_acc[0] = SENT;
        post_acc[1] = SENT;
        pres_pend = 1'b0;
        post_pres = SENT;
        dropped = -1;
        mis_pulses = 0;
        acc_count = 0;
        first_acc_cyc = -1;
        first_val_cyc = -1;
        val_count = 0;
        win_lo = 0;
        win_hi = 0;
        last_acc = SENT;
        seen_err8 = 1'b0;
        data_at8 = 32'h0;
    endtask

    task automatic apply_reset(input logic m32);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_stall", o_stall, 1);
        chk("rst_req_valid", mem_bus.req_valid, 0);
        chk("rst_misaligned", o_err_misaligned, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_instr_addr", o_instr_addr, 0);
        mem_bus.req_ready = 1'b0;
        mem_bus.rsp_valid = 1'b0;
        mem_bus.rsp_data = '0;
        mem_bus.rsp_err = 1'b0;
        i_instr_ready = 1'b0;
        i_32b_mode = m32;
        mem_q.delete();
        exp_pc = '0;
        exp_req_pc = '0;
        exp_mis = 1'b0;
        clear_stats();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic cycle();
        logic        acc, cons, redir, fired;
        logic [63:0] nia, seq;
        pend_t       p;
        @(negedge i_clk);
        chk("stall", o_stall, !o_instr_valid);
        chk("misaligned", o_err_misaligned, exp_mis);
        if (o_err_misaligned) mis_pulses++;
        if (o_instr_valid) begin
            chk("instr_addr", o_instr_addr, exp_pc);
            chk("instr_data", o_instr, mem_word(exp_pc));
            chk("instr_err", o_instr_err, exp_pc == err_addr);
            if (first_val_cyc < 0) first_val_cyc = cyc;
            if (cyc >= win_lo && cyc < win_hi) val_count++;
            if (pres_pend) begin
                post_pres = o_instr_addr;
                pres_pend = 1'b0;
            end
            if (o_instr_addr == 64'd8) begin
                data_at8 = o_instr;
                if (o_instr_err) seen_err8 = 1'b1;
            end
        end
        if (mem_bus.req_valid) chk("req_addr", mem_bus.req_addr, exp_req_pc);

        mem_bus.req_ready = ($urandom_range(99) < mem_rdy_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            p = mem_q.pop_front();
            mem_bus.rsp_valid = 1'b1;
            mem_bus.rsp_data = mem_word(p.addr);
            mem_bus.rsp_err = (p.addr == err_addr);
        end else begin
            mem_bus.rsp_valid = 1'b0;
            mem_bus.rsp_data = $urandom;
            mem_bus.rsp_err = 1'($urandom_range(1));
        end

        acc = mem_bus.req_valid && mem_bus.req_ready;
        if (acc) begin
            p.addr = mem_bus.req_addr;
            p.due = cyc + $urandom_range(lat_max, lat_min);
            mem_q.push_back(p);
            acc_count++;
            last_acc = mem_bus.req_addr;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (cap_on && cap_n < 2) begin
                post_acc[cap_n] = mem_bus.req_addr;
                cap_n++;
            end
        end

        i_instr_ready = ($urandom_range(99) < cons_pct);
        cons = o_instr_valid && i_instr_ready;
        seq = msk(exp_pc + 64'd4, i_32b_mode);
        fired = 1'b0;
        if (!cons) nia = {$urandom, $urandom};
        else if (arm_en && exp_pc == arm_at) begin
            nia = arm_to;
            arm_en = 1'b0;
            fired = 1'b1;
        end else if ($urandom_range(99) < redir_pct) nia = rand_target(i_32b_mode);
        else nia = seq;
        i_next_instr_addr = nia;

        redir = cons && (nia != seq);
        exp_mis = cons && (nia[1:0] != 2'b00);
        if (cons) exp_pc = msk(nia, i_32b_mode);
        if (redir) exp_req_pc = msk(nia, i_32b_mode);
        else if (acc) exp_req_pc = msk(exp_req_pc + 64'd4, i_32b_mode);
        if (fired) begin
            cap_on = 1'b1;
            cap_n = 0;
            pres_pend = 1'b1;
            dropped = mem_q.size() + int'(mem_bus.rsp_valid);
        end
        cyc++;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int cns, input int rd);
        lat_min = lmin;
        lat_max = lmax;
        mem_rdy_pct = rdy;
        cons_pct = cns;
        redir_pct = rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        err_addr = NO_ERR;
        set_knobs(1, 1, 100, 100, 0);
        clear_stats();

        // Straight-line fetch, 1-cycle memory, everyone ready.
        apply_reset(1'b0);
        win_lo = cyc + 6;
        win_hi = cyc + 16;
        repeat (20) cycle();
        chk("first_latency", 64'(first_val_cyc - first_acc_cyc), 2);
        chk("steady_valid", val_count, 10);
        chk("word_at_8", data_at8, 32'h1000_0002);

        // Stalled consumer: credit limit stops issue after DEPTH requests.
        apply_reset(1'b0);
        set_knobs(1, 1, 100, 0, 0);
        repeat (10) cycle();
        chk("stall_accepts", acc_count, DEPTH);
        chk("stall_last_req", last_acc, 64'd12);
        chk("stall_req_valid", mem_bus.req_valid, 0);
        cons_pct = 100;
        cap_on = 1'b1;
        cap_n = 0;
        repeat (15) cycle();
        chk("resume_addr", post_acc[0], 64'd16);

        // Redirect with requests outstanding.
        apply_reset(1'b0);
        set_knobs(3, 3, 100, 100, 0);
        arm_en = 1'b1;
        arm_at = 64'd4;
        arm_to = 64'h200;
        repeat (25) cycle();
        chk("redir_dropped", dropped, 3);
        chk("redir_req", post_acc[0], 64'h200);
        chk("redir_pres", post_pres, 64'h200);

        // Memory error on one word.
        apply_reset(1'b0);
        set_knobs(1, 1, 100, 100, 0);
        err_addr = 64'd8;
        repeat (15) cycle();
        chk("err_entry", seen_err8, 1);
        err_addr = NO_ERR;

        // 32-bit mode wrap.
        apply_reset(1'b1);
        arm_en = 1'b1;
        arm_at = 64'd0;
        arm_to = 64'hFFFF_FFFF_FFFF_FFFC;
        repeat (15) cycle();
        chk("m32_req", post_acc[0], 64'h0000_0000_FFFF_FFFC);
        chk("m32_wrap_req", post_acc[1], 64'd0);
        chk("m32_pres", post_pres, 64'h0000_0000_FFFF_FFFC);

        // Misaligned redirect, then reset while traffic is flowing.
        apply_reset(1'b0);
        set_knobs(2, 2, 100, 100, 0);
        arm_en = 1'b1;
        arm_at = 64'd4;
        arm_to = 64'h102;
        repeat (12) cycle();
        chk("mis_pulses", mis_pulses, 1);
        chk("mis_req", post_acc[0], 64'h100);
        chk("mis_pres", post_pres, 64'h100);
        apply_reset(1'b0);

        // Randomized traffic, 64-bit then 32-bit mode.
        set_knobs(1, 4, 75, 70, 10);
        err_addr = 64'h40;
        repeat (2500) cycle();
        apply_reset(1'b1);
        set_knobs(1, 4, 75, 70, 10);
        err_addr = 64'h40;
        repeat (1500) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
